// File: rtl/bp_pkg.sv
// Shared parameters, BTB entry layout and counter helper for the branch predictor.
package bp_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned PHT_ENTRIES = 32;
    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned GHR_W       = 5;
    localparam int unsigned PHT_IDX_W   = $clog2(PHT_ENTRIES);
    localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_LSB     = BTB_IDX_W + 2;
    localparam int unsigned TAG_W       = XLEN - TAG_LSB;
    localparam int unsigned CNT_W       = 16;

    localparam logic [1:0]  PHT_INIT    = 2'b01;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic             is_jump;
    } btb_entry_t;

    // 2-bit saturating counter step: up on taken, down otherwise.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        nxt = ctr;
        if (up && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!up && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, registered write port.
module bp_btb
    import bp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTB_IDX_W-1:0] i_lkp_idx,
    input  logic [TAG_W-1:0]     i_lkp_tag,
    output logic                 o_hit,
    output logic [XLEN-1:0]      o_target,
    output logic                 o_is_jump,
    input  logic                 i_wr_en,
    input  logic [BTB_IDX_W-1:0] i_wr_idx,
    input  btb_entry_t           i_wr_entry
);

    btb_entry_t r_mem [BTB_ENTRIES];
    btb_entry_t w_entry;
    logic       w_hit;

    // Entry storage; a write lands at the edge so same-cycle lookups see the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_entry;
        end
    end

    // Tag compare; target reads as zero on a miss.
    always_comb begin
        w_entry   = r_mem[i_lkp_idx];
        w_hit     = w_entry.valid && (w_entry.tag == i_lkp_tag);
        o_hit     = w_hit;
        o_target  = w_hit ? w_entry.target : '0;
        o_is_jump = w_hit && w_entry.is_jump;
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor with BTB, EX-stage mispredict detection and perf counters.
module branch_predictor
    import bp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      F_PC,
    output logic                 F_pred_taken,
    output logic [PHT_IDX_W-1:0] F_pht_idx,
    output logic                 F_btb_hit,
    output logic [XLEN-1:0]      F_btb_target,
    input  logic                 E_upd_valid,
    input  logic                 E_is_cond,
    input  logic [XLEN-1:0]      E_PC,
    input  logic [XLEN-1:0]      E_target,
    input  logic                 E_taken,
    input  logic                 E_pred_taken,
    input  logic [PHT_IDX_W-1:0] E_pht_idx,
    input  logic                 E_btb_hit,
    input  logic [XLEN-1:0]      E_btb_target,
    output logic                 E_mispredict,
    output logic [XLEN-1:0]      E_redirect_pc,
    output logic [CNT_W-1:0]     br_count,
    output logic [CNT_W-1:0]     mis_count
);

    logic [1:0]           r_pht [PHT_ENTRIES];
    logic [GHR_W-1:0]     r_ghr;
    logic [CNT_W-1:0]     r_br_count;
    logic [CNT_W-1:0]     r_mis_count;

    logic [PHT_IDX_W-1:0] w_pht_idx;
    logic [1:0]           w_pht_ctr;
    logic                 w_btb_hit;
    logic [XLEN-1:0]      w_btb_target;
    logic                 w_btb_jump;
    logic                 w_cond_upd;
    logic                 w_btb_wr;
    btb_entry_t           w_btb_wr_entry;
    logic                 w_unused;

    // E_btb_hit is carried for symmetry only; PC byte offset never matters.
    assign w_unused = ^{E_btb_hit, F_PC[1:0]};

    assign w_cond_upd = E_upd_valid && E_is_cond;
    assign w_btb_wr   = E_upd_valid && E_taken;

    // Only taken transfers allocate; JAL/JALR entries are marked as unconditional.
    always_comb begin
        w_btb_wr_entry         = '0;
        w_btb_wr_entry.valid   = 1'b1;
        w_btb_wr_entry.tag     = E_PC[XLEN-1:TAG_LSB];
        w_btb_wr_entry.target  = E_target;
        w_btb_wr_entry.is_jump = !E_is_cond;
    end

    bp_btb u_btb (
        .clk        (clk),
        .rst        (rst),
        .i_lkp_idx  (F_PC[TAG_LSB-1:2]),
        .i_lkp_tag  (F_PC[XLEN-1:TAG_LSB]),
        .o_hit      (w_btb_hit),
        .o_target   (w_btb_target),
        .o_is_jump  (w_btb_jump),
        .i_wr_en    (w_btb_wr),
        .i_wr_idx   (E_PC[TAG_LSB-1:2]),
        .i_wr_entry (w_btb_wr_entry)
    );

    // Fetch-side lookup; prediction is forced quiet while reset is held.
    always_comb begin
        w_pht_idx    = F_PC[PHT_IDX_W+1:2] ^ r_ghr;
        w_pht_ctr    = r_pht[w_pht_idx];
        F_pht_idx    = rst ? F_PC[PHT_IDX_W+1:2] : w_pht_idx;
        F_btb_hit    = !rst && w_btb_hit;
        F_btb_target = rst ? '0 : w_btb_target;
        F_pred_taken = !rst && w_btb_hit && (w_btb_jump || w_pht_ctr[1]);
    end

    // Resolution: wrong direction, or taken to a target other than the predicted one.
    always_comb begin
        E_mispredict  = E_upd_valid &&
                        ((E_taken != E_pred_taken) ||
                         (E_taken && (E_target != E_btb_target)));
        E_redirect_pc = E_taken ? E_target : E_PC + XLEN'(4);
    end

    // PHT and global history train on conditional branches only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PHT_ENTRIES); i++) begin
                r_pht[i] <= PHT_INIT;
            end
            r_ghr <= '0;
        end else if (w_cond_upd) begin
            r_pht[E_pht_idx] <= sat_step(r_pht[E_pht_idx], E_taken);
            r_ghr            <= {r_ghr[GHR_W-2:0], E_taken};
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else begin
            if (E_upd_valid && (r_br_count != '1)) begin
                r_br_count <= r_br_count + CNT_W'(1);
            end
            if (E_mispredict && (r_mis_count != '1)) begin
                r_mis_count <= r_mis_count + CNT_W'(1);
            end
        end
    end

    assign br_count  = r_br_count;
    assign mis_count = r_mis_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: reference model, vector table, directed corners, random traffic.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] F_PC;
    logic        F_pred_taken;
    logic [4:0]  F_pht_idx;
    logic        F_btb_hit;
    logic [31:0] F_btb_target;
    logic        E_upd_valid, E_is_cond, E_taken, E_pred_taken, E_btb_hit;
    logic [31:0] E_PC, E_target, E_btb_target;
    logic [4:0]  E_pht_idx;
    logic        E_mispredict;
    logic [31:0] E_redirect_pc;
    logic [15:0] br_count, mis_count;

    branch_predictor dut (
        .clk(clk), .rst(rst), .F_PC(F_PC), .F_pred_taken(F_pred_taken),
        .F_pht_idx(F_pht_idx), .F_btb_hit(F_btb_hit), .F_btb_target(F_btb_target),
        .E_upd_valid(E_upd_valid), .E_is_cond(E_is_cond), .E_PC(E_PC),
        .E_target(E_target), .E_taken(E_taken), .E_pred_taken(E_pred_taken),
        .E_pht_idx(E_pht_idx), .E_btb_hit(E_btb_hit), .E_btb_target(E_btb_target),
        .E_mispredict(E_mispredict), .E_redirect_pc(E_redirect_pc),
        .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] fpc;
        logic        v, cond;
        logic [31:0] epc, etgt;
        logic        taken, pt;
        logic [4:0]  pidx;
        logic        bhit;
        logic [31:0] btgt;
    } in_t;

    typedef struct {
        in_t         in;
        logic        exp_mis;
        logic [31:0] exp_redir;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference state, kept as plain arrays and integers.
    int          m_pht [32];
    logic [31:0] m_ghr;
    bit          m_bv [16];
    logic [31:0] m_btag [16];
    logic [31:0] m_btgt [16];
    bit          m_bj [16];
    int          m_br, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; m_bj[i] = 0;
        end
        m_ghr = 0; m_br = 0; m_mis = 0;
    endfunction

    function automatic bit m_mispred();
        return E_upd_valid && ((E_taken != E_pred_taken) || (E_taken && (E_target != E_btb_target)));
    endfunction

    function automatic in_t upd(input logic [31:0] fpc, input logic v, input logic cond,
                                input logic [31:0] epc, input logic [31:0] etgt,
                                input logic taken, input logic pt, input logic [4:0] pidx,
                                input logic [31:0] btgt);
        in_t s;
        s.rst = 1'b0; s.fpc = fpc; s.v = v; s.cond = cond; s.epc = epc; s.etgt = etgt;
        s.taken = taken; s.pt = pt; s.pidx = pidx; s.bhit = 1'b0; s.btgt = btgt;
        return s;
    endfunction

    function automatic in_t idle(input logic [31:0] fpc);
        return upd(fpc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0);
    endfunction

    // Compare every output against the model for the currently driven inputs.
    task automatic check_all();
        logic [31:0] bi, idx, tgt, redir;
        bit          hit, pred;
        bi    = (F_PC >> 2) & 32'hF;
        hit   = m_bv[bi[3:0]] && (m_btag[bi[3:0]] == (F_PC >> 6));
        idx   = ((F_PC >> 2) & 32'h1F) ^ m_ghr;
        pred  = hit && (m_bj[bi[3:0]] || (m_pht[idx[4:0]] >= 2));
        tgt   = hit ? m_btgt[bi[3:0]] : 32'h0;
        redir = E_taken ? E_target : E_PC + 32'd4;
        chk("m_pred",  32'(F_pred_taken), 32'(pred));
        chk("m_idx",   32'(F_pht_idx), idx);
        chk("m_hit",   32'(F_btb_hit), 32'(hit));
        chk("m_tgt",   F_btb_target, tgt);
        chk("m_mis",   32'(E_mispredict), 32'(m_mispred()));
        chk("m_redir", E_redirect_pc, redir);
        chk("m_brc",   32'(br_count), 32'(m_br));
        chk("m_misc",  32'(mis_count), 32'(m_mis));
    endtask

    task automatic drive(input in_t s);
        @(negedge clk);
        rst = s.rst; F_PC = s.fpc; E_upd_valid = s.v; E_is_cond = s.cond;
        E_PC = s.epc; E_target = s.etgt; E_taken = s.taken; E_pred_taken = s.pt;
        E_pht_idx = s.pidx; E_btb_hit = s.bhit; E_btb_target = s.btgt;
        if (s.rst) m_reset();
        #1;
        check_all();
    endtask

    // Advance one edge and apply the architectural update rules to the model.
    task automatic commit();
        logic [3:0] k;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (E_upd_valid) begin
            if (m_mispred() && m_mis < 65535) m_mis++;
            if (m_br < 65535) m_br++;
            if (E_is_cond) begin
                if (E_taken && m_pht[E_pht_idx] < 3) m_pht[E_pht_idx]++;
                else if (!E_taken && m_pht[E_pht_idx] > 0) m_pht[E_pht_idx]--;
                m_ghr = ((m_ghr << 1) | 32'(E_taken)) & 32'h1F;
            end
            if (E_taken) begin
                k = E_PC[5:2];
                m_bv[k] = 1; m_btag[k] = E_PC >> 6; m_btgt[k] = E_target; m_bj[k] = !E_is_cond;
            end
        end
    endtask

    task automatic step(input in_t s);
        drive(s);
        commit();
    endtask

    task automatic do_reset();
        in_t s;
        s = idle(32'h0);
        s.rst = 1'b1;
        step(s);
    endtask

    vec_t tbl [7];
    in_t  s;

    initial begin
        tbl[0] = '{upd(0, 1, 1, 32'h1FC, 32'h0, 0, 1, 0, 32'h0), 1'b1, 32'h200};
        tbl[1] = '{upd(0, 1, 1, 32'h100, 32'h200, 1, 1, 1, 32'h200), 1'b0, 32'h200};
        tbl[2] = '{upd(0, 1, 1, 32'h100, 32'h204, 1, 1, 2, 32'h200), 1'b1, 32'h204};
        tbl[3] = '{upd(0, 1, 1, 32'h80, 32'h10, 0, 0, 3, 32'h999), 1'b0, 32'h84};
        tbl[4] = '{upd(0, 1, 1, 32'hFFFFFFFC, 32'h4, 0, 0, 4, 32'h0), 1'b0, 32'h0};
        tbl[5] = '{upd(0, 1, 0, 32'h20, 32'h40, 1, 0, 5, 32'h40), 1'b1, 32'h40};
        tbl[6] = '{upd(0, 0, 1, 32'h24, 32'h44, 1, 0, 6, 32'h0), 1'b0, 32'h44};

        rst = 1'b1; F_PC = 0; E_upd_valid = 0; E_is_cond = 0; E_PC = 0; E_target = 0;
        E_taken = 0; E_pred_taken = 0; E_pht_idx = 0; E_btb_hit = 0; E_btb_target = 0;
        m_reset();

        // Reset state: index passes F_PC through untouched.
        s = idle(32'h7C); s.rst = 1'b1;
        drive(s);
        chk("rst_idx", 32'(F_pht_idx), 32'h1F);
        chk("rst_pred", 32'(F_pred_taken), 32'h0);
        commit();

        drive(idle(32'h100));
        chk("cold_hit", 32'(F_btb_hit), 32'h0);
        chk("cold_pred", 32'(F_pred_taken), 32'h0);
        chk("cold_idx", 32'(F_pht_idx), 32'h0);
        commit();

        // Two taken conditional resolutions at 0x100 -> 0x200, both predicted not-taken.
        for (int i = 0; i < 2; i++) begin
            drive(upd(32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 5'd0, 32'h0));
            chk("c2_mis", 32'(E_mispredict), 32'h1);
            chk("c2_redir", E_redirect_pc, 32'h200);
            commit();
        end
        drive(idle(32'h100));
        chk("c2_hit", 32'(F_btb_hit), 32'h1);
        chk("c2_tgt", F_btb_target, 32'h200);
        chk("c2_ghr", 32'(F_pht_idx), 32'h03);
        chk("c2_misc", 32'(mis_count), 32'd2);
        chk("c2_brc", 32'(br_count), 32'd2);
        commit();

        // JAL 0x40 -> 0x80: not visible in the write cycle, predicted taken after.
        drive(upd(32'h40, 1, 0, 32'h40, 32'h80, 1, 0, 5'd0, 32'h0));
        chk("jal_same", 32'(F_btb_hit), 32'h0);
        commit();
        drive(idle(32'h40));
        chk("jal_pred", 32'(F_pred_taken), 32'h1);
        chk("jal_tgt", F_btb_target, 32'h80);
        chk("jal_ghr", 32'(F_pht_idx), 32'd19);
        commit();

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            chk($sformatf("tbl%0d_mis", i), 32'(E_mispredict), 32'(tbl[i].exp_mis));
            chk($sformatf("tbl%0d_redir", i), E_redirect_pc, tbl[i].exp_redir);
            commit();
        end

        // PHT saturation: fill BTB with conditional entries, then train entry 3.
        do_reset();
        for (int i = 0; i < 16; i++)
            step(upd(0, 1, 1, 32'(i * 4), 32'h1000 + 32'(i * 4), 1, 0, 5'd31, 32'h0));
        for (int i = 0; i < 5; i++) step(upd(0, 1, 1, 32'h0, 32'h1000, 1, 0, 5'd3, 32'h0));
        step(upd(0, 1, 1, 32'h0, 32'h0, 0, 0, 5'd3, 32'h0));
        for (int i = 0; i < 5; i++) step(upd(0, 1, 1, 32'h0, 32'h0, 0, 0, 5'd20, 32'h0));
        drive(idle(32'h0C));
        chk("sat_hi", 32'(F_pred_taken), 32'h1);
        commit();
        for (int i = 0; i < 5; i++) step(upd(0, 1, 1, 32'h0, 32'h0, 0, 0, 5'd3, 32'h0));
        step(upd(0, 1, 1, 32'h0, 32'h1000, 1, 0, 5'd3, 32'h0));
        for (int i = 0; i < 5; i++) step(upd(0, 1, 1, 32'h0, 32'h0, 0, 0, 5'd20, 32'h0));
        drive(idle(32'h0C));
        chk("sat_lo", 32'(F_pred_taken), 32'h0);
        commit();

        // Reset coinciding with a valid update must win.
        s = upd(32'h100, 1, 1, 32'h100, 32'h200, 1, 0, 5'd0, 32'h0); s.rst = 1'b1;
        step(s);
        drive(idle(32'h100));
        chk("rstupd_hit", 32'(F_btb_hit), 32'h0);
        chk("rstupd_brc", 32'(br_count), 32'h0);
        chk("rstupd_misc", 32'(mis_count), 32'h0);
        chk("rstupd_idx", 32'(F_pht_idx), 32'h0);
        commit();

        // Random traffic over a small PC set so BTB/PHT aliasing is exercised.
        for (int n = 0; n < 2000; n++) begin
            s.rst   = ($urandom_range(0, 299) == 0);
            s.fpc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            s.v     = ($urandom_range(0, 3) != 0);
            s.cond  = $urandom_range(0, 1) != 0;
            s.epc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            s.etgt  = 32'($urandom_range(0, 255)) << 2;
            s.taken = $urandom_range(0, 1) != 0;
            s.pt    = $urandom_range(0, 1) != 0;
            s.pidx  = 5'($urandom_range(0, 31));
            s.bhit  = $urandom_range(0, 1) != 0;
            s.btgt  = ($urandom_range(0, 1) != 0) ? s.etgt : 32'($urandom_range(0, 255)) << 2;
            step(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
